// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between the register interface and the NCO sweep sequencer.
`timescale 1ns/1ps
interface nco_sweep_ctrl_if #(
   parameter int NCO_FREQ_BITS = 4,
   parameter int DWELL_BITS    = 8
) ();
   logic                     start_in;
   logic                     abort_in;
   logic                     repeat_in;
   logic [NCO_FREQ_BITS-1:0] fcw_start_in;
   logic [NCO_FREQ_BITS-1:0] fcw_stop_in;
   logic [NCO_FREQ_BITS-1:0] fcw_step_in;
   logic [DWELL_BITS-1:0]    dwell_in;
   logic [NCO_FREQ_BITS-1:0] fcw_out;
   logic                     busy_out;
   logic                     step_out;
   logic                     done_out;
   logic                     state_dbg;   // 0 = IDLE, 1 = DWELL

   modport master (
      output start_in, abort_in, repeat_in, fcw_start_in, fcw_stop_in, fcw_step_in, dwell_in,
      input  fcw_out, busy_out, step_out, done_out, state_dbg
   );

   modport slave (
      input  start_in, abort_in, repeat_in, fcw_start_in, fcw_stop_in, fcw_step_in, dwell_in,
      output fcw_out, busy_out, step_out, done_out, state_dbg
   );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the NCO frequency control word from start to stop,
// holding each value for dwell+1 cycles, up or down, with optional continuous repeat.
`timescale 1ns/1ps
module nco_sweep_ctrl #(
   parameter int NCO_FREQ_BITS = 4,
   parameter int DWELL_BITS    = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   nco_sweep_ctrl_if.slave      bus
);
   localparam int W = NCO_FREQ_BITS;

   typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

   // Handshake: start_in is a request accepted on any edge where the FSM is IDLE and
   // abort_in is low; busy_out is the acknowledgement and stays high until the sweep ends.
   state_t                state_q, state_d;
   logic [W-1:0]          fcw_q, fcw_d;
   logic [DWELL_BITS-1:0] cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  step_q, step_d;
   logic                  done_q, done_d;
   logic [W-1:0]          start_q, start_d;
   logic [W-1:0]          stop_q, stop_d;
   logic [W-1:0]          inc_q, inc_d;
   logic [DWELL_BITS-1:0] dwell_q, dwell_d;
   logic                  rep_q, rep_d;
   logic                  up_q, up_d;

   logic [W:0]   sum_w;
   logic [W:0]   diff_w;
   logic [W-1:0] next_fcw;

   // Zero step is latched as 1 so every sweep makes progress toward stop.
   always_comb begin
      sum_w  = {1'b0, fcw_q} + {1'b0, inc_q};
      diff_w = {1'b0, fcw_q} - {1'b0, inc_q};
      if (up_q) begin
         next_fcw = (sum_w > {1'b0, stop_q}) ? stop_q : sum_w[W-1:0];
      end else begin
         next_fcw = (diff_w[W] || (diff_w[W-1:0] < stop_q)) ? stop_q : diff_w[W-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      fcw_d   = fcw_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      step_d  = 1'b0;
      done_d  = 1'b0;
      start_d = start_q;
      stop_d  = stop_q;
      inc_d   = inc_q;
      dwell_d = dwell_q;
      rep_d   = rep_q;
      up_d    = up_q;
      if (bus.abort_in) begin
         state_d = IDLE;
         fcw_d   = '0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start_in) begin
                  start_d = bus.fcw_start_in;
                  stop_d  = bus.fcw_stop_in;
                  inc_d   = (bus.fcw_step_in == '0) ? W'(1) : bus.fcw_step_in;
                  dwell_d = bus.dwell_in;
                  rep_d   = bus.repeat_in;
                  up_d    = (bus.fcw_start_in <= bus.fcw_stop_in);
                  fcw_d   = bus.fcw_start_in;
                  cnt_d   = bus.dwell_in;
                  busy_d  = 1'b1;
                  step_d  = 1'b1;
                  state_d = DWELL;
               end
            end
            DWELL: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else if (fcw_q != stop_q) begin
                  fcw_d  = next_fcw;
                  cnt_d  = dwell_q;
                  step_d = 1'b1;
               end else if (rep_q) begin
                  fcw_d  = start_q;
                  cnt_d  = dwell_q;
                  step_d = 1'b1;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         fcw_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
         start_q <= '0;
         stop_q  <= '0;
         inc_q   <= '0;
         dwell_q <= '0;
         rep_q   <= 1'b0;
         up_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         fcw_q   <= fcw_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         step_q  <= step_d;
         done_q  <= done_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         inc_q   <= inc_d;
         dwell_q <= dwell_d;
         rep_q   <= rep_d;
         up_q    <= up_d;
      end
   end

   assign bus.fcw_out   = fcw_q;
   assign bus.busy_out  = busy_q;
   assign bus.step_out  = step_q;
   assign bus.done_out  = done_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomised bench for nco_sweep_ctrl: each sweep's cycle-by-cycle output trace is
// derived from the list of FCW values the sweep should visit.
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;
   localparam int NW = 4;
   localparam int DW = 8;
   localparam int EW = NW + 3;   // {fcw, busy, step, done}

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;
   logic [EW-1:0] exp_q[$];

   nco_sweep_ctrl_if #(.NCO_FREQ_BITS(NW), .DWELL_BITS(DW)) bus ();

   nco_sweep_ctrl #(.NCO_FREQ_BITS(NW), .DWELL_BITS(DW)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] pk(input int f, input bit b, input bit s, input bit d);
      logic [31:0] fv;
      fv = f;
      return {fv[NW-1:0], b, s, d};
   endfunction

   task automatic scramble_cfg();
      bus.fcw_start_in = NW'($urandom_range(0, 15));
      bus.fcw_stop_in  = NW'($urandom_range(0, 15));
      bus.fcw_step_in  = NW'($urandom_range(0, 15));
      bus.dwell_in     = DW'($urandom_range(0, 7));
      bus.repeat_in    = 1'($urandom_range(0, 1));
   endtask

   // abort_at: index of the trace entry replaced by the abort result (-1 = no abort)
   task automatic run_sweep(input int s, input int e, input int st, input int d,
                            input bit rep, input int abort_at);
      int vals[$];
      int v, stp, n_done;
      logic [EW-1:0] w;
      stp = (st == 0) ? 1 : st;
      v = s;
      vals.push_back(v);
      while (v != e) begin
         if (s <= e) v = (v + stp > e) ? e : v + stp;
         else        v = (v - stp < e) ? e : v - stp;
         vals.push_back(v);
      end
      n_done = vals.size() * (d + 1);
      if (!rep && abort_at > n_done) abort_at = n_done;
      exp_q.delete();
      do begin
         foreach (vals[i])
            for (int j = 0; j <= d; j++) exp_q.push_back(pk(vals[i], 1'b1, j == 0, 1'b0));
      end while (rep && exp_q.size() <= abort_at);
      if (!rep) begin
         exp_q.push_back(pk(e, 1'b0, 1'b0, 1'b1));
         exp_q.push_back(pk(e, 1'b0, 1'b0, 1'b0));
      end
      if (abort_at >= 0) begin
         while (exp_q.size() > abort_at) void'(exp_q.pop_back());
         exp_q.push_back(pk(0, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(pk(0, 1'b0, 1'b0, 1'b0));
      end

      @(negedge clk_in);
      bus.fcw_start_in = NW'(s);
      bus.fcw_stop_in  = NW'(e);
      bus.fcw_step_in  = NW'(st);
      bus.dwell_in     = DW'(d);
      bus.repeat_in    = rep;
      bus.abort_in     = 1'b0;
      bus.start_in     = 1'b1;
      for (int k = 0; exp_q.size() > 0; k++) begin
         @(posedge clk_in);
         #1;
         w = exp_q.pop_front();
         check("fcw",  32'(bus.fcw_out),  32'(w[EW-1:3]));
         check("busy", 32'(bus.busy_out), 32'(w[2]));
         check("step", 32'(bus.step_out), 32'(w[1]));
         check("done", 32'(bus.done_out), 32'(w[0]));
         bus.abort_in = (k == abort_at - 1);
         if (w[2]) begin
            bus.start_in = 1'($urandom_range(0, 1));
            scramble_cfg();
         end else begin
            bus.start_in = 1'b0;
         end
      end
      bus.abort_in = 1'b0;
      bus.start_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout act=%0d exp=0", n_total);
      $fatal(1, "timeout");
   end

   initial begin
      bus.start_in = 1'b0;
      bus.abort_in = 1'b0;
      scramble_cfg();
      repeat (2) @(negedge clk_in);
      check("rst_fcw",  32'(bus.fcw_out),  0);
      check("rst_busy", 32'(bus.busy_out), 0);
      check("rst_step", 32'(bus.step_out), 0);
      check("rst_done", 32'(bus.done_out), 0);
      rst_in = 1'b0;

      // directed scenarios
      run_sweep(2, 9, 3, 1, 1'b0, -1);
      run_sweep(12, 3, 4, 0, 1'b0, -1);
      run_sweep(10, 15, 7, 2, 1'b0, -1);
      run_sweep(5, 7, 0, 0, 1'b0, -1);
      run_sweep(1, 3, 1, 0, 1'b1, 10);
      run_sweep(6, 6, 2, 3, 1'b0, -1);
      run_sweep(0, 15, 15, 0, 1'b0, -1);
      run_sweep(15, 0, 9, 1, 1'b0, -1);

      // start together with abort in IDLE is refused
      @(negedge clk_in);
      bus.start_in = 1'b1;
      bus.abort_in = 1'b1;
      @(posedge clk_in);
      #1;
      check("sa_busy", 32'(bus.busy_out), 0);
      check("sa_fcw",  32'(bus.fcw_out),  0);
      check("sa_step", 32'(bus.step_out), 0);
      bus.start_in = 1'b0;
      bus.abort_in = 1'b0;

      // reset asserted between edges in the middle of a sweep
      @(negedge clk_in);
      bus.fcw_start_in = 4'd2;
      bus.fcw_stop_in  = 4'd9;
      bus.fcw_step_in  = 4'd3;
      bus.dwell_in     = 8'd1;
      bus.repeat_in    = 1'b0;
      bus.start_in     = 1'b1;
      @(posedge clk_in);
      #1;
      bus.start_in = 1'b0;
      check("pre_rst_busy", 32'(bus.busy_out), 1);
      repeat (2) @(posedge clk_in);
      #3;
      rst_in = 1'b1;
      #1;
      check("mrst_fcw",  32'(bus.fcw_out),  0);
      check("mrst_busy", 32'(bus.busy_out), 0);
      check("mrst_step", 32'(bus.step_out), 0);
      check("mrst_done", 32'(bus.done_out), 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      run_sweep(4, 11, 2, 1, 1'b0, -1);

      // random sweeps, some aborted
      for (int i = 0; i < 40; i++) begin
         int s, e, st, d, ab;
         bit rep;
         s   = $urandom_range(0, 15);
         e   = $urandom_range(0, 15);
         st  = $urandom_range(0, 15);
         d   = $urandom_range(0, 4);
         rep = ($urandom_range(0, 3) == 0);
         if (rep) ab = $urandom_range(1, 40);
         else     ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
         run_sweep(s, e, st, d, rep, ab);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the frequency control word (FCW) input of the team's phase-accumulator NCO. On a start request it steps the FCW from a start value to a stop value. Each FCW value is held for a programmable dwell time. Sweeps run up or down, with optional continuous repeat. It sits between the control/register interface and the NCO, which consumes fcw_out directly.

Parameters:
NCO_FREQ_BITS, 4, width of all FCW values (start, stop, step, output)
DWELL_BITS, 8, width of the dwell counter / dwell_in

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-high
start_in  input  1  start request, sampled only in IDLE
abort_in  input  1  stop sweep immediately, any state
repeat_in  input  1  1 = restart from start value after reaching stop; sampled with start_in
fcw_start_in  input  NCO_FREQ_BITS  first FCW of sweep
fcw_stop_in  input  NCO_FREQ_BITS  last FCW of sweep
fcw_step_in  input  NCO_FREQ_BITS  FCW increment magnitude
dwell_in  input  DWELL_BITS  each FCW held for dwell_in+1 cycles
fcw_out  output  NCO_FREQ_BITS  registered FCW to NCO
busy_out  output  1  sweep in progress
step_out  output  1  one-cycle pulse on every fcw_out update during a sweep
done_out  output  1  one-cycle pulse when a non-repeat sweep completes

Behaviour:
- Async reset:
  - state IDLE.
  - fcw_out=0, busy_out=0, step_out=0, done_out=0.
  - Dwell counter and latched config cleared.
- Config latch:
  - On an accepted start, latch fcw_start_in, fcw_stop_in, fcw_step_in, dwell_in and repeat_in.
  - Input changes during a sweep have no effect.
- Direction: up if start<=stop, else down. Fixed for the whole sweep.
- Step of zero is treated as step of 1.
- States: IDLE, DWELL.
- IDLE:
  - At an edge with start_in=1 and abort_in=0: fcw_out<=fcw_start_in, cnt<=dwell_in, busy_out<=1, step_out<=1, go to DWELL.
  - fcw_out otherwise holds its last value.
- DWELL, cnt!=0: cnt decrements, fcw_out holds.
- DWELL, cnt==0 (expiry), and fcw_out!=stop:
  - Up: next = fcw_out+step, computed at NCO_FREQ_BITS+1 bits. If the sum is > stop (including carry out), next = stop.
  - Down: next = fcw_out-step. If borrow occurs or the result is < stop, next = stop.
  - fcw_out<=next, cnt<=dwell, step_out pulse.
- DWELL, cnt==0, and fcw_out==stop:
  - repeat=0: busy_out<=0, done_out pulse, go to IDLE. fcw_out holds stop.
  - repeat=1: fcw_out<=start, cnt<=dwell, step_out pulse, stay in DWELL. No done_out.
- Timing: fcw_out changes every dwell+1 cycles. A sweep of N distinct values asserts done_out N*(dwell+1) edges after the start edge.
- start==stop: single value held dwell+1 cycles, then done (or repeats the same value with step_out each period).
- Abort:
  - Any state, next edge: state IDLE, fcw_out<=0, busy_out<=0.
  - No done_out or step_out that cycle.
  - Abort overrides a simultaneous start or expiry.
- start_in while busy: ignored (no restart, no error).
- step_out and done_out are never both 1 in the same cycle. Both are low outside the events above.

Test Plan:
- Reset mid-sweep (assert rst_in between edges) -> fcw_out=0, busy_out=0, done_out=0, step_out=0 immediately; start on the next clean cycle works normally.
- Up sweep: start=2, stop=9, step=3, dwell=1, repeat=0 -> fcw_out 2,5,8,9, each for 2 cycles; step_out 4 pulses; done_out 8 edges after start; busy_out low from that edge; fcw_out stays 9.
- Down sweep with clamp: start=12, stop=3, step=4, dwell=0 -> fcw_out 12,8,4,3 on consecutive edges; done_out at edge 4.
- Overflow clamp: start=10, stop=15, step=7, dwell=2 -> fcw_out 10 (3 cycles), then 15 (3 cycles, no wrap to 1), then done; step=0 with start=5, stop=7 -> 5,6,7.
- Repeat: start=1, stop=3, step=1, dwell=0, repeat=1 -> 1,2,3,1,2,3,...; done_out never asserts; busy_out stays 1. Then abort -> next edge fcw_out=0, busy_out=0, no done_out.
- Simultaneous events:
  - start+abort in IDLE -> stays IDLE.
  - start_in pulsed while busy, with changed config -> sweep unaffected.
  - start==stop=6, dwell=3 -> one step_out, done_out 4 edges after start.
